// File: rtl/output_sched.sv
// Round-robin frame scheduler feeding output_stage: grants one requester at a time,
// strobes its frame in, then holds off for serialization, CRC and the inter-frame gap.
//
// state | meaning
// IDLE  | waiting for an eligible request, arbitration and capture on the exit edge
// LOAD  | gnt/vld_ch/data outputs presented for one cycle
// SEND  | frame plus CRC being serialized downstream, counter runs eff+CRC_LEN..1
// GAP   | enforced idle between frames, counter runs GAP..1
module output_sched #(
  parameter int N_CH    = 8,
  parameter int DATA_W  = 128,
  parameter int CRC_LEN = 16,
  parameter int GAP     = 2,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk_out16x,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH*DATA_W-1:0]   req_data,
  input  logic [N_CH*16-1:0]       req_len,
  output logic [N_CH-1:0]          gnt,
  output logic [DATA_W-1:0]        data_gray,
  output logic [N_CH-1:0]          vld_ch,
  output logic [15:0]              data_count,
  output logic                     busy,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     frame_done,
  output logic                     err_len
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic [N_CH-1:0]     gnt_q, gnt_d;
  logic [N_CH-1:0]     vld_q, vld_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [15:0]         count_q, count_d;
  logic [CH_W-1:0]     cur_q, cur_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [N_CH-1:0]     elig;
  logic                found;
  logic [CH_W-1:0]     sel;
  logic [CH_W-1:0]     idx;
  logic [N_CH-1:0]     sel_oh;
  logic [15:0]         len_sel;
  logic [DATA_W-1:0]   data_sel;
  logic [15:0]         eff;
  logic                len_bad;

  assign elig = req & ch_en;

  // Search upward from the channel after the last grant, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = CH_W'((int'(last_q) + i) % N_CH);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    len_sel  = '0;
    data_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == CH_W'(k)) begin
        len_sel  = req_len[k*16 +: 16];
        data_sel = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_oh = N_CH'(1) << sel;

  // Zero-length frames are dropped; over-long frames are clipped to DATA_W.
  always_comb begin
    eff     = len_sel;
    len_bad = 1'b0;
    if (len_sel == 16'd0) begin
      eff     = 16'd0;
      len_bad = 1'b1;
    end else if (len_sel > 16'(DATA_W)) begin
      eff     = 16'(DATA_W);
      len_bad = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = '0;
    vld_d   = '0;
    data_d  = data_q;
    count_d = count_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_LOAD;
          gnt_d   = sel_oh;
          last_d  = sel;
          cur_d   = sel;
          err_d   = len_bad;
          if (eff != 16'd0) begin
            vld_d   = sel_oh;
            data_d  = data_sel;
            count_d = eff;
            cnt_d   = eff + 16'(CRC_LEN);
          end else begin
            cnt_d   = 16'(GAP);
          end
        end
      end
      // vld_q is nonzero exactly when the captured frame has a nonzero length.
      S_LOAD: begin
        state_d = (vld_q != '0) ? S_SEND : S_GAP;
      end
      S_SEND: begin
        if (cnt_q <= 16'd1) begin
          state_d = S_GAP;
          cnt_d   = 16'(GAP);
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q <= 16'd1) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d   = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk_out16x or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= CH_W'(N_CH - 1);
      gnt_q   <= '0;
      vld_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      cur_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      count_q <= count_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign gnt        = gnt_q;
  assign vld_ch     = vld_q;
  assign data_gray  = data_q;
  assign data_count = count_q;
  assign cur_ch     = cur_q;
  assign frame_done = done_q;
  assign err_len    = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/output_sched.md
# output_sched

Round-robin frame scheduler that sits in front of `output_stage` in the `clk_out16x` domain. Up to `N_CH` requesters each offer one 128-bit Gray-coded frame with a bit length. The scheduler grants one requester at a time and strobes that frame into `output_stage` with a one-hot `vld_ch`. It then holds off further loads until serialization, CRC and the inter-frame gap have elapsed.

## Interface
- `N_CH`, 8: number of requesters/output channels.
- `DATA_W`, 128: frame width; also the maximum frame length in bits.
- `CRC_LEN`, 16: CRC bits appended by `output_stage` per frame.
- `GAP`, 2: idle cycles enforced between frames (≥1).

Ports:
- `clk_out16x` in 1: single clock.
- `rst` in 1: asynchronous reset, active-high.
- `req` in `N_CH`: per-channel request; held with data until its `gnt` pulse.
- `ch_en` in `N_CH`: per-channel enable mask; a disabled channel is never granted.
- `req_data` in `N_CH*DATA_W`: frames, channel k at `[k*DATA_W +: DATA_W]`.
- `req_len` in `N_CH*16`: frame length in bits, channel k at `[k*16 +: 16]`.
- `gnt` out `N_CH`: one-cycle acceptance pulse to the requester.
- `data_gray` out `DATA_W`: frame to `output_stage`.
- `vld_ch` out `N_CH`: one-hot load strobe to `output_stage`.
- `data_count` out 16: effective bit count to `output_stage`.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `cur_ch` out `$clog2(N_CH)`: channel of the last grant.
- `frame_done` out 1: one-cycle pulse at the end of a sent frame.
- `err_len` out 1: one-cycle pulse, coincident with `gnt`, when the length is illegal.

## Operation
- FSM states: IDLE, LOAD, SEND, GAP.
- **IDLE:** `elig = req & ch_en`.
  - If nonzero, select the first set bit searching upward from `(last+1) mod N_CH`, wrapping around.
  - Register `k` and the channel's data/length, then go to LOAD.
- **Length rules:**
  - `eff = 0`: drop the frame.
  - `1..DATA_W`: `eff = req_len`.
  - `> DATA_W`: `eff = DATA_W`.
  - `err_len` fires for lengths of 0 and for lengths greater than `DATA_W`.
- **LOAD (1 cycle):**
  - `gnt[k]=1` and `last<=k`.
  - If `eff ≠ 0`: `vld_ch=1<<k`, drive `data_gray`/`data_count=eff`, set `cur_ch=k`, and go to SEND with counter `= eff+CRC_LEN`.
  - If `eff = 0`: `vld_ch` stays 0, `cur_ch=k`, and go straight to GAP. No `frame_done` is issued.
- **SEND:** decrement the counter each cycle; leave for GAP when it reaches 1, so SEND lasts exactly `eff+CRC_LEN` cycles.
- **GAP:** lasts `GAP` cycles, then returns to IDLE. `frame_done` pulses in the first GAP cycle, but only for frames that were actually sent.
- **Held outputs:** `data_gray` and `data_count` hold their last loaded value outside LOAD; `vld_ch` and `gnt` are 0 outside LOAD.
- **Mid-frame input changes:** changes to `ch_en`, `req` or `req_data` after LOAD do not affect the frame in flight.
- **Reset:** all outputs go to 0 immediately. `last` resets to `N_CH-1`, so ch0 has the highest priority first. FSM goes to IDLE and the counter clears. Reset asserted mid-SEND aborts the frame with no `frame_done`.
- **Width rules:** the counter is 16 bits (maximum value `DATA_W+CRC_LEN`), and all length comparisons are unsigned.

## Timing
- Everything is registered on the rising edge of `clk_out16x`; there are no combinational input-to-output paths.
- If `elig≠0` is sampled at edge T, then `gnt`, `vld_ch`, `data_gray` and `data_count` are valid in cycle T+1.
- SEND occupies cycles T+2 .. T+1+eff+CRC_LEN.
- `frame_done` occurs at T+2+eff+CRC_LEN.
- IDLE is re-entered at T+2+eff+CRC_LEN+GAP. The next grant is therefore at the earliest one cycle later.
- Per-frame period is `eff+CRC_LEN+GAP+2` cycles; for example 148 cycles for `eff=128`, `CRC_LEN=16`, `GAP=2`.
- A dropped frame (len 0) occupies `GAP+2` cycles.
- A `req` deasserted before its grant is simply not selected; there is no penalty.

## Test plan
- **Single frame:** ch3, `req_len=64`, `req_data=128'h0123..CDEF`, decision at T.
  - `gnt=8'h08`, `vld_ch=8'h08` and `data_count=64` for exactly one cycle at T+1.
  - `frame_done` at T+82; `busy` low from T+84.
- **All channels requesting:** `req=8'hFF`, `ch_en=8'hFF`, all `len=8`.
  - Grants in order ch0,1,…,7,0, spaced 28 cycles apart.
  - `vld_ch` is always one-hot.
- **Illegal lengths:**
  - ch1 `len=0`: `gnt[1]` and `err_len` pulse, `vld_ch` stays 0, no `frame_done`, IDLE after 4 cycles.
  - ch2 `len=200`: `err_len` pulses, `data_count=128`, SEND lasts 144 cycles.
- **Enable mask:** `req=8'hFF`, `ch_en=8'h0A`.
  - Grants alternate ch1, ch3 only.
  - Clearing `ch_en[3]` mid-SEND of ch3 still completes that frame, and ch3 is never granted afterwards.
- **Reset mid-frame:** assert `rst` 20 cycles into the SEND of ch5.
  - All outputs are 0 within the same cycle; no `frame_done`.
  - After release with `req=8'h21`, the first grant goes to ch0.
- **Data stability:** change `req_data[k]` during SEND.
  - `data_gray` keeps the LOAD value until the next LOAD.
